// File: rtl/tqvp_vgacon_ctrl.sv
// rtl/tqvp_vgacon_ctrl.sv - 3x10 text console controller writing a character cell buffer.
// Optional feature macro: VGACON_SCROLL_EN (scroll on row overflow instead of wrapping to the top).
module tqvp_vgacon_ctrl #(
    parameter logic [8:0] FILL_WORD = 9'h020
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_data,
    output logic       busy,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       buf_we,
    output logic [4:0] buf_waddr,
    output logic [8:0] buf_wdata,
    output logic [4:0] buf_raddr,
    input  logic [8:0] buf_rdata
);

`ifdef VGACON_SCROLL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_CLEAR = 2'd2, S_SCROLL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_CLEAR = 2'd2} state_t;
`endif

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [8:0] data_q, data_d;
    logic       adv_row;
    logic [6:0] code;
    logic [4:0] cell_addr;

    assign code       = in_data[6:0];
    assign cell_addr  = {3'b000, row_q} * 5'd10 + {1'b0, col_q};
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE) || rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        adv_row = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (code >= 7'h20 && code <= 7'h7E) begin
                        data_d  = in_data;
                        state_d = S_WRITE;
                    end else begin
                        case (code)
                            7'h0A: begin
                                col_d   = 4'd0;
                                adv_row = 1'b1;
                            end
                            7'h0D: col_d = 4'd0;
                            7'h08: if (col_q != 4'd0) col_d = col_q - 4'd1;
                            7'h0C: begin
                                state_d = S_CLEAR;
                                cnt_d   = 5'd0;
                                row_d   = 2'd0;
                                col_d   = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (col_q == 4'd9) begin
                    col_d   = 4'd0;
                    adv_row = 1'b1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
`ifdef VGACON_SCROLL_EN
            S_SCROLL: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd29) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            end
`endif
            S_CLEAR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd29) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Row overflow: scroll the text up one row, or wrap to the top-left cell.
        if (adv_row) begin
            if (row_q == 2'd2) begin
`ifdef VGACON_SCROLL_EN
                state_d = S_SCROLL;
                cnt_d   = 5'd0;
                row_d   = 2'd2;
`else
                row_d   = 2'd0;
`endif
                col_d = 4'd0;
            end else begin
                row_d = row_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= 5'd0;
            row_q   <= 2'd0;
            col_q   <= 4'd0;
            data_q  <= FILL_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

`ifndef VGACON_SCROLL_EN
    logic unused_rdata;
    assign unused_rdata = ^buf_rdata;
`endif

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = cnt_q;
        buf_wdata = FILL_WORD;
        buf_raddr = 5'd0;
        case (state_q)
            S_WRITE: begin
                buf_we    = !rst;
                buf_waddr = cell_addr;
                buf_wdata = data_q;
            end
            S_CLEAR: buf_we = !rst;
`ifdef VGACON_SCROLL_EN
            S_SCROLL: begin
                buf_we = !rst;
                if (cnt_q < 5'd20) begin
                    buf_raddr = cnt_q + 5'd10;
                    buf_wdata = buf_rdata;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tqvp_vgacon_ctrl.sv
// tb/tb_tqvp_vgacon_ctrl.sv - scoreboard bench for tqvp_vgacon_ctrl (both VGACON_SCROLL_EN builds).
module tb_tqvp_vgacon_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       busy;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       buf_we;
    logic [4:0] buf_waddr;
    logic [8:0] buf_wdata;
    logic [4:0] buf_raddr;
    logic [8:0] buf_rdata;

    int checks = 0;
    int errors = 0;
    int n;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;
    logic [8:0]  mem[32];
    logic [8:0]  exp_mem[30];

    tqvp_vgacon_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .cursor_row(cursor_row), .cursor_col(cursor_col), .buf_we(buf_we),
        .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mem[i] = 9'h000;
    always @(posedge clk) if (buf_we) mem[buf_waddr] <= buf_wdata;
    assign buf_rdata = mem[buf_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0d data %0h expected no write", buf_waddr, buf_wdata);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write", {18'd0, buf_waddr, buf_wdata}, {18'd0, mon_e});
            end
        end
    end

    task automatic push_write(input int a, input logic [8:0] d);
        exp_q.push_back({a[4:0], d});
        exp_mem[a] = d;
    endtask

    task automatic push_clear(input int cnt);
        for (int i = 0; i < cnt; i++) push_write(i, 9'h020);
    endtask

    task automatic push_scroll(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < 20) push_write(i, exp_mem[i+10]);
            else push_write(i, 9'h020);
        end
    endtask

    task automatic send_begin(input logic [8:0] d);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] d);
        send_begin(d);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic expect_cursor(input string tag, input int r, input int c);
        check(tag, {26'd0, cursor_row, cursor_col}, (r << 4) | c);
    endtask

    task automatic put_char(input int a, input logic [8:0] d);
        int cyc;
        push_write(a, d);
        send(d);
        wait_idle(cyc);
        check("write_busy_cycles", cyc, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 9'h000;
        for (int i = 0; i < 30; i++) exp_mem[i] = 9'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, buf_we}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        expect_cursor("rst_cursor", 0, 0);

        push_clear(30);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(n);
        check("reset_clear_cycles", n, 30);
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);
        expect_cursor("post_reset_cursor", 0, 0);
        check("reset_queue_drained", exp_q.size(), 0);

        put_char(0, 9'h141);
        expect_cursor("first_char_cursor", 0, 1);
        check("first_char_ready", {31'd0, in_ready}, 32'd1);

        send(9'h00D);
        wait_idle(n);
        check("cr_busy", n, 0);
        expect_cursor("cr_cursor", 0, 0);

        for (int i = 0; i < 10; i++) put_char(i, {i[1:0], 7'h41 + 7'(i)});
        expect_cursor("row0_wrap_cursor", 1, 0);

        send(9'h008);
        wait_idle(n);
        expect_cursor("bs_col0_cursor", 1, 0);

        for (int i = 0; i < 3; i++) put_char(10 + i, {2'd2, 7'h30 + 7'(i)});
        send(9'h008);
        wait_idle(n);
        expect_cursor("bs_cursor", 1, 2);
        put_char(12, 9'h07A);
        expect_cursor("overwrite_cursor", 1, 3);

        send(9'h07F);
        send(9'h001);
        wait_idle(n);
        check("ignored_busy", n, 0);
        expect_cursor("ignored_cursor", 1, 3);

        send(9'h00A);
        for (int i = 0; i < 5; i++) put_char(20 + i, {2'd3, 7'h61 + 7'(i)});
        expect_cursor("row2_cursor", 2, 5);

`ifdef VGACON_SCROLL_EN
        push_scroll(30);
        send(9'h00A);
        wait_idle(n);
        check("scroll_busy_cycles", n, 30);
        expect_cursor("scroll_cursor", 2, 0);
`else
        send(9'h00A);
        wait_idle(n);
        check("lf_wrap_busy", n, 0);
        expect_cursor("lf_wrap_cursor", 0, 0);
        send(9'h00A);
        send(9'h00A);
        wait_idle(n);
        expect_cursor("lf_lf_cursor", 2, 0);
`endif

        for (int i = 0; i < 7; i++) put_char(20 + i, {2'd1, 7'h4B + 7'(i)});
        expect_cursor("pre_ff_cursor", 2, 7);
        push_clear(30);
        send(9'h00C);
        wait_idle(n);
        check("ff_clear_cycles", n, 30);
        expect_cursor("ff_cursor", 0, 0);

        send(9'h00A);
        send(9'h00A);
        for (int i = 0; i < 9; i++) put_char(20 + i, {2'd2, 7'h21 + 7'(i)});
        expect_cursor("pre_wrap_cursor", 2, 9);
        push_write(29, 9'h17E);
`ifdef VGACON_SCROLL_EN
        push_scroll(30);
        send(9'h17E);
        wait_idle(n);
        check("write_scroll_cycles", n, 31);
        expect_cursor("write_scroll_cursor", 2, 0);
        push_scroll(12);
        send_begin(9'h00A);
`else
        send(9'h17E);
        wait_idle(n);
        check("write_wrap_cycles", n, 1);
        expect_cursor("write_wrap_cursor", 0, 0);
        push_clear(12);
        send_begin(9'h00C);
`endif
        in_data = 9'h141;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midop_rst_we", {31'd0, buf_we}, 32'd0);
        check("midop_rst_ready", {31'd0, in_ready}, 32'd0);
        check("midop_rst_busy", {31'd0, busy}, 32'd1);
        check("midop_partial_drained", exp_q.size(), 0);
        push_clear(30);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(n);
        check("midop_clear_cycles", n, 30);
        expect_cursor("midop_cursor", 0, 0);
        check("midop_ready", {31'd0, in_ready}, 32'd1);
        push_write(0, 9'h141);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle(n);
        check("held_char_busy", n, 1);
        expect_cursor("held_char_cursor", 0, 1);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
